// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [31:0]       pc_plus4_i,
    input  logic [31:0]       rs_data_i,
    input  logic [31:0]       rt_data_i,
    input  logic [31:0]       imm_ext_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [9:0]        ctrl_i,
    input  logic              flush_i,
    output logic [31:0]       pc_plus4_o,
    output logic [31:0]       rs_data_o,
    output logic [31:0]       rt_data_o,
    output logic [31:0]       imm_ext_o,
    output logic [4:0]        rs_addr_o,
    output logic [4:0]        rt_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [9:0]        ctrl_o,
    output logic              ex_valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_plus4_q, rs_data_q, rt_data_q, imm_ext_q;
    logic [4:0]       rs_addr_q, rt_addr_q, rd_addr_q;
    logic [9:0]       ctrl_q, ctrl_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic bubble;

    // A load in EX whose destination feeds the instruction in ID; $0 never counts.
    assign hazard = ex_valid_q & ctrl_q[7] & (rt_addr_q != 5'd0) & id_valid_i &
                    ((rt_addr_q == rs_addr_i) | (rt_addr_q == rt_addr_i));
    assign stall_o = hazard & ~flush_i;
    assign bubble  = stall_o | flush_i;

    always_comb begin
        ctrl_d      = ctrl_i;
        ex_valid_d  = id_valid_i;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // An invalid or squashed slot must never carry control into EX.
        if (bubble || !id_valid_i) begin
            ctrl_d     = 10'd0;
            ex_valid_d = 1'b0;
        end
        if (stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_i && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_plus4_q  <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_ext_q   <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            ctrl_q      <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_plus4_q  <= pc_plus4_i;
            rs_data_q   <= rs_data_i;
            rt_data_q   <= rt_data_i;
            imm_ext_q   <= imm_ext_i;
            rs_addr_q   <= rs_addr_i;
            rt_addr_q   <= rt_addr_i;
            rd_addr_q   <= rd_addr_i;
            ctrl_q      <= ctrl_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_plus4_o  = pc_plus4_q;
    assign rs_data_o   = rs_data_q;
    assign rt_data_o   = rt_data_q;
    assign imm_ext_o   = imm_ext_q;
    assign rs_addr_o   = rs_addr_q;
    assign rt_addr_o   = rt_addr_q;
    assign rd_addr_o   = rd_addr_q;
    assign ctrl_o      = ctrl_q;
    assign ex_valid_o  = ex_valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX-side state plus
// directed scenario tasks; a second instance with CNT_W=2 exercises saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] pc_plus4 = '0, rs_data = '0, rt_data = '0, imm_ext = '0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
    logic [9:0]  ctrl = '0;
    logic        flush = 1'b0;

    logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic [9:0]  ctrl_o;
    logic        ex_valid_o, stall_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] pc2_o, rsd2_o, rtd2_o, imm2_o;
    logic [4:0]  rsa2_o, rta2_o, rda2_o;
    logic [9:0]  ctrl2_o;
    logic        v2_o, stall2_o;
    logic [1:0]  scnt2_o, fcnt2_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .pc_plus4_i(pc_plus4), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_ext_i(imm_ext),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .ctrl_i(ctrl), .flush_i(flush),
        .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_ext_o(imm_ext_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .ctrl_o(ctrl_o), .ex_valid_o(ex_valid_o), .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_ex_stage #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .pc_plus4_i(pc_plus4), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_ext_i(imm_ext),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .ctrl_i(ctrl), .flush_i(flush),
        .pc_plus4_o(pc2_o), .rs_data_o(rsd2_o), .rt_data_o(rtd2_o), .imm_ext_o(imm2_o),
        .rs_addr_o(rsa2_o), .rt_addr_o(rta2_o), .rd_addr_o(rda2_o),
        .ctrl_o(ctrl2_o), .ex_valid_o(v2_o), .stall_o(stall2_o),
        .stall_cnt_o(scnt2_o), .flush_cnt_o(fcnt2_o)
    );

    typedef struct packed {
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rsa, rta, rda;
        logic [9:0]  ctrl;
        logic        v;
        logic [15:0] sc, fc;
        logic [1:0]  sc2, fc2;
    } exp_t;

    exp_t m;          // expected registered state after the next edge
    exp_t exp_q[$];
    logic exp_stall;

    function automatic exp_t observed();
        return {pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o, rs_addr_o, rt_addr_o,
                rd_addr_o, ctrl_o, ex_valid_o, stall_cnt_o, flush_cnt_o, scnt2_o, fcnt2_o};
    endfunction

    // Drive one ID-stage slot and push what EX must hold after the next edge.
    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] a_rs,
                         input logic [4:0] a_rt, input logic [4:0] a_rd,
                         input logic fl, input logic [31:0] imm);
        logic hz, bub;
        id_valid = v; ctrl = c; rs_addr = a_rs; rt_addr = a_rt; rd_addr = a_rd;
        flush = fl; imm_ext = imm;
        pc_plus4 = $urandom; rs_data = $urandom; rt_data = $urandom;
        hz  = m.v & m.ctrl[7] & (m.rta != 5'd0) & v & ((m.rta == a_rs) | (m.rta == a_rt));
        exp_stall = hz & ~fl;
        bub = exp_stall | fl;
        m.pc = pc_plus4; m.rsd = rs_data; m.rtd = rt_data; m.imm = imm;
        m.rsa = a_rs; m.rta = a_rt; m.rda = a_rd;
        m.ctrl = (bub || !v) ? 10'd0 : c;
        m.v    = v & ~bub;
        if (exp_stall && m.sc != 16'hFFFF) m.sc = m.sc + 16'd1;
        if (exp_stall && m.sc2 != 2'd3)    m.sc2 = m.sc2 + 2'd1;
        if (fl && m.fc != 16'hFFFF)        m.fc = m.fc + 16'd1;
        if (fl && m.fc2 != 2'd3)           m.fc2 = m.fc2 + 2'd1;
        exp_q.push_back(m);
    endtask

    task automatic nop();
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        exp_q.delete();
        m = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard consumer: every edge, the DUT state must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got %h expected %h", $time, observed(), e);
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        id_valid = 1'b1; ctrl = 10'h080; rs_addr = 5'd8; rt_addr = 5'd8;
        m = '0;
        @(posedge clk); #1;
        n_checks++;
        if (observed() !== exp_t'('0) || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h stall=%b required all zero", observed(), stall_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 10'h3A8, 5'd1, 5'd2, 5'd5, 1'b0, 32'hFFFF8000);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL pass_stall: got %b required 0", stall_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ctrl_o !== 10'h3A8 || imm_ext_o !== 32'hFFFF8000 || rd_addr_o !== 5'd5 || ex_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_through: got ctrl=%h imm=%h rd=%0d v=%b required 3a8 ffff8000 5 1",
                     ctrl_o, imm_ext_o, rd_addr_o, ex_valid_o);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] sc0;
        nop();
        sc0 = stall_cnt_o;
        drive(1'b1, 10'h390, 5'd1, 5'd8, 5'd0, 1'b0, 32'd4);
        @(posedge clk); #1;
        drive(1'b1, 10'h20A, 5'd8, 5'd2, 5'd3, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: got %b required 1", stall_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ctrl_o !== 10'd0 || ex_valid_o !== 1'b0 || stall_cnt_o !== sc0 + 16'd1) begin
            n_fail++;
            $display("FAIL load_use_bubble: got ctrl=%h v=%b scnt=%0d required 0 0 %0d",
                     ctrl_o, ex_valid_o, stall_cnt_o, sc0 + 16'd1);
        end
        drive(1'b1, 10'h20A, 5'd8, 5'd2, 5'd3, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: got %b required 0", stall_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ctrl_o !== 10'h20A || ex_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL load_use_enter: got ctrl=%h v=%b required 20a 1", ctrl_o, ex_valid_o);
        end
    endtask

    task automatic test_no_hazard();
        nop();
        drive(1'b1, 10'h390, 5'd1, 5'd0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 10'h20A, 5'd0, 5'd0, 5'd7, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reg_zero: got stall=%b required 0", stall_o);
        end
        @(posedge clk); #1;
        drive(1'b1, 10'h390, 5'd1, 5'd9, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 10'h20A, 5'd3, 5'd4, 5'd7, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL no_match: got stall=%b required 0", stall_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_over_hazard();
        do_reset();
        drive(1'b1, 10'h390, 5'd1, 5'd8, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 10'h20A, 5'd8, 5'd2, 5'd3, 1'b1, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b required 0", stall_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ctrl_o !== 10'd0 || ex_valid_o !== 1'b0 || flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got ctrl=%h v=%b fcnt=%0d scnt=%0d required 0 0 1 0",
                     ctrl_o, ex_valid_o, flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        int   exp_seq[5] = '{1, 2, 3, 3, 3};
        int   k = 0;
        logic s;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'h080, 5'd8, 5'd8, 5'd0, 1'b0, 32'd0);
            #1;
            s = stall_o;
            @(posedge clk); #1;
            if (s && k < 5) begin
                n_checks++;
                if (scnt2_o !== 2'(exp_seq[k])) begin
                    n_fail++; $display("FAIL sat_seq[%0d]: got %0d required %0d", k, scnt2_o, exp_seq[k]);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 5 || stall_cnt_o !== 16'd5) begin
            n_fail++; $display("FAIL sat_count: got stalls=%0d scnt=%0d required 5 5", k, stall_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        nop();
        drive(1'b1, 10'h390, 5'd1, 5'd8, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 10'h20A, 5'd8, 5'd2, 5'd3, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL async_pre_stall: got %b required 1", stall_o);
        end
        #1;
        rst = 1'b1;
        exp_q.delete();
        m = '0;
        #1;
        n_checks++;
        if (observed() !== exp_t'('0) || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h stall=%b required all zero", observed(), stall_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 10'h1F3, 5'd6, 5'd7, 5'd9, 1'b0, 32'h1234);
        @(posedge clk); #1;
        n_checks++;
        if (ctrl_o !== 10'h1F3 || ex_valid_o !== 1'b1 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL first_load: got ctrl=%h v=%b scnt=%0d required 1f3 1 0", ctrl_o, ex_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(($urandom % 4) != 0, 10'($urandom), 5'($urandom % 4), 5'($urandom % 4),
                  5'($urandom % 32), ($urandom % 8) == 0, $urandom);
            #1;
            n_checks++;
            if (stall_o !== exp_stall) begin
                n_fail++; $display("FAIL b2b_stall[%0d]: got %b required %b", i, stall_o, exp_stall);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_hazard();
        test_flush_over_hazard();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        nop();
        @(posedge clk); #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
